lfsr_stream_packer: RTL and testbench

//  Downstream consumer of the LFSR core output. Samples lfsr_out each enabled cycle into a sync FIFO.

---
 rtl/lfsr_pkg.sv | 18 +
 rtl/lfsr_sync_fifo.sv | 54 +++++
 rtl/lfsr_stream_packer.sv | 93 +++++++++
 tb/tb_lfsr_stream_packer.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/lfsr_pkg.sv
// Shared constants for the LFSR subsystem (stream packer, AXI-Lite slave).
package lfsr_pkg;

  localparam int unsigned LFSR_DATA_W     = 8;
  localparam int unsigned LFSR_FIFO_DEPTH = 16;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam int unsigned CTRL_EN_BIT   = 0;
  localparam int unsigned CTRL_LOAD_BIT = 1;

  typedef struct packed {
    logic [LFSR_DATA_W-1:0] data;
    logic                   last;
  } axis_beat_t;

endpackage

// File: rtl/lfsr_sync_fifo.sv
// First-word-fall-through synchronous FIFO; pointers carry an extra MSB
// so full and empty are distinguished without a separate counter.
module lfsr_sync_fifo
  import lfsr_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = LFSR_DATA_W,
  parameter int unsigned FIFO_DEPTH = LFSR_FIFO_DEPTH
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          clr,
  input  logic                          push,
  input  logic                          pop,
  input  logic [DATA_WIDTH-1:0]         wdata,
  output logic [DATA_WIDTH-1:0]         rdata,
  output logic                          empty,
  output logic                          full,
  output logic [$clog2(FIFO_DEPTH):0]   level
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW:0]           wr_ptr;
  logic [AW:0]           rd_ptr;

  always_ff @(posedge clk) begin
    if (push && !clr) begin
      mem[wr_ptr[AW-1:0]] <= wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_comb begin
    empty = (wr_ptr == rd_ptr);
    full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    level = wr_ptr - rd_ptr;
    // Head is forced to zero when empty so tdata reads 0 out of reset.
    rdata = empty ? '0 : mem[rd_ptr[AW-1:0]];
  end

endmodule

// File: rtl/lfsr_stream_packer.sv
// Packs LFSR samples into an AXI-Stream with tlast every pkt_len beats.
// Optional drop counter output enabled by LFSR_STREAM_DROP_CNT_EN.
module lfsr_stream_packer
  import lfsr_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = LFSR_DATA_W,
  parameter int unsigned FIFO_DEPTH = LFSR_FIFO_DEPTH,
  parameter int unsigned CNT_WIDTH  = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          sample_en,
  input  logic [DATA_WIDTH-1:0]         lfsr_data,
  input  logic                          clr,
  input  logic [CNT_WIDTH-1:0]          pkt_len,
  output logic [DATA_WIDTH-1:0]         m_axis_tdata,
  output logic                          m_axis_tvalid,
  input  logic                          m_axis_tready,
  output logic                          m_axis_tlast,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow
`ifdef LFSR_STREAM_DROP_CNT_EN
  ,
  output logic [15:0]                   drop_cnt
`endif
);

  logic                 empty;
  logic                 full;
  logic                 pop;
  logic                 push;
  logic                 drop;
  logic [CNT_WIDTH-1:0] beat_cnt;
  logic [CNT_WIDTH-1:0] len_q;
  logic [CNT_WIDTH-1:0] len_eff;

  lfsr_sync_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .clr   (clr),
    .push  (push),
    .pop   (pop),
    .wdata (lfsr_data),
    .rdata (m_axis_tdata),
    .empty (empty),
    .full  (full),
    .level (fifo_level)
  );

  always_comb begin
    m_axis_tvalid = ~empty;
    pop           = m_axis_tvalid & m_axis_tready;
    push          = sample_en & (~full | pop);
    drop          = sample_en & full & ~pop;
    len_eff       = (beat_cnt == '0) ? pkt_len : len_q;
    // Modulo subtraction makes pkt_len=0 mean a full 2**CNT_WIDTH packet.
    m_axis_tlast  = m_axis_tvalid & (beat_cnt == (len_eff - CNT_WIDTH'(1)));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      beat_cnt <= '0;
      len_q    <= '0;
      overflow <= 1'b0;
    end else if (clr) begin
      beat_cnt <= '0;
      len_q    <= '0;
      overflow <= 1'b0;
    end else begin
      if (pop) begin
        beat_cnt <= m_axis_tlast ? '0 : beat_cnt + CNT_WIDTH'(1);
        if (beat_cnt == '0) len_q <= pkt_len;
      end
      if (drop) overflow <= 1'b1;
    end
  end

`ifdef LFSR_STREAM_DROP_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drop_cnt <= '0;
    end else if (clr) begin
      drop_cnt <= '0;
    end else if (drop && (drop_cnt != '1)) begin
      drop_cnt <= drop_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_lfsr_stream_packer.sv
// Directed self-checking bench for lfsr_stream_packer.
module tb_lfsr_stream_packer;

  logic       clk = 1'b0;
  logic       rst;
  logic       sample_en;
  logic [7:0] lfsr_data;
  logic       clr;
  logic [7:0] pkt_len;
  logic [7:0] m_axis_tdata;
  logic       m_axis_tvalid;
  logic       m_axis_tready;
  logic       m_axis_tlast;
  logic [4:0] fifo_level;
  logic       overflow;
`ifdef LFSR_STREAM_DROP_CNT_EN
  logic [15:0] drop_cnt;
`endif

  int total = 0;
  int bad   = 0;

  logic [7:0] exp_data [4];

  lfsr_stream_packer #(
    .DATA_WIDTH (8),
    .FIFO_DEPTH (16),
    .CNT_WIDTH  (8)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .sample_en     (sample_en),
    .lfsr_data     (lfsr_data),
    .clr           (clr),
    .pkt_len       (pkt_len),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tlast  (m_axis_tlast),
    .fifo_level    (fifo_level),
    .overflow      (overflow)
`ifdef LFSR_STREAM_DROP_CNT_EN
    ,
    .drop_cnt      (drop_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_clr();
    clr = 1'b1;
    step();
    clr = 1'b0;
  endtask

  // mode 0: 256-beat packets; mode 1: pkt_len 4 -> 2 after beat 1; mode 2: len 3
  task automatic stream_beats(input int n, input int mode);
    logic exp_last;
    for (int i = 1; i <= n; i++) begin
      case (mode)
        0:       exp_last = (i % 256 == 0);
        1:       exp_last = (i == 4) || (i > 4 && i % 2 == 0);
        default: exp_last = (i % 3 == 0);
      endcase
      chk($sformatf("stream%0d_tvalid_b%0d", mode, i), {31'd0, m_axis_tvalid}, 32'd1);
      chk($sformatf("stream%0d_tlast_b%0d", mode, i), {31'd0, m_axis_tlast}, {31'd0, exp_last});
      step();
      if (mode == 1 && i == 1) pkt_len = 8'd2;
    end
  endtask

  initial begin
    rst = 1'b1;
    sample_en = 1'b0;
    lfsr_data = 8'h00;
    clr = 1'b0;
    pkt_len = 8'd2;
    m_axis_tready = 1'b0;
    exp_data[0] = 8'hA1; exp_data[1] = 8'hB2; exp_data[2] = 8'hC3; exp_data[3] = 8'hD4;
    step();
    step();
    chk("rst_tvalid", {31'd0, m_axis_tvalid}, 32'd0);
    chk("rst_tlast", {31'd0, m_axis_tlast}, 32'd0);
    chk("rst_tdata", {24'd0, m_axis_tdata}, 32'd0);
    chk("rst_level", {27'd0, fifo_level}, 32'd0);
    chk("rst_overflow", {31'd0, overflow}, 32'd0);
`ifdef LFSR_STREAM_DROP_CNT_EN
    chk("rst_drop_cnt", {16'd0, drop_cnt}, 32'd0);
`endif
    rst = 1'b0;
    step();

    // 1: basic stream, pkt_len=2
    m_axis_tready = 1'b1;
    sample_en = 1'b1;
    lfsr_data = exp_data[0];
    chk("t1_pre_tvalid", {31'd0, m_axis_tvalid}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      step();
      lfsr_data = (i < 3) ? exp_data[i+1] : 8'h00;
      if (i == 3) sample_en = 1'b0;
      chk($sformatf("t1_tvalid_%0d", i), {31'd0, m_axis_tvalid}, 32'd1);
      chk($sformatf("t1_tdata_%0d", i), {24'd0, m_axis_tdata}, {24'd0, exp_data[i]});
      chk($sformatf("t1_tlast_%0d", i), {31'd0, m_axis_tlast}, {31'd0, (i % 2 == 1)});
    end
    step();
    chk("t1_end_tvalid", {31'd0, m_axis_tvalid}, 32'd0);
    chk("t1_end_level", {27'd0, fifo_level}, 32'd0);

    // 2: backpressure and overflow
    m_axis_tready = 1'b0;
    sample_en = 1'b1;
    for (int i = 0; i < 20; i++) begin
      lfsr_data = 8'h10 + 8'(i);
      step();
    end
    sample_en = 1'b0;
    chk("t2_level", {27'd0, fifo_level}, 32'd16);
    chk("t2_overflow", {31'd0, overflow}, 32'd1);
`ifdef LFSR_STREAM_DROP_CNT_EN
    chk("t2_drop_cnt", {16'd0, drop_cnt}, 32'd4);
`endif
    chk("t2_tdata_stall", {24'd0, m_axis_tdata}, 32'h10);
    m_axis_tready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("t2_drain_%0d", i), {24'd0, m_axis_tdata}, 32'h10 + i);
      step();
    end
    chk("t2_empty_tvalid", {31'd0, m_axis_tvalid}, 32'd0);
    chk("t2_overflow_sticky", {31'd0, overflow}, 32'd1);

    // 3: full FIFO with simultaneous push and pop
    do_clr();
    chk("t3_clr_overflow", {31'd0, overflow}, 32'd0);
`ifdef LFSR_STREAM_DROP_CNT_EN
    chk("t3_clr_drop_cnt", {16'd0, drop_cnt}, 32'd0);
`endif
    m_axis_tready = 1'b0;
    sample_en = 1'b1;
    for (int i = 0; i < 16; i++) begin
      lfsr_data = 8'h20 + 8'(i);
      step();
    end
    chk("t3_full_level", {27'd0, fifo_level}, 32'd16);
    m_axis_tready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      lfsr_data = 8'h40 + 8'(i);
      chk($sformatf("t3_head_%0d", i), {24'd0, m_axis_tdata}, 32'h20 + i);
      step();
      chk($sformatf("t3_level_%0d", i), {27'd0, fifo_level}, 32'd16);
    end
    sample_en = 1'b0;
    chk("t3_overflow", {31'd0, overflow}, 32'd0);
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("t3_drain_%0d", i), {24'd0, m_axis_tdata},
          (i < 11) ? 32'h25 + i : 32'h40 + (i - 11));
      step();
    end
    chk("t3_empty", {31'd0, m_axis_tvalid}, 32'd0);

    // 4a: pkt_len=0 gives 256-beat packets
    pkt_len = 8'd0;
    sample_en = 1'b1;
    lfsr_data = 8'h5A;
    do_clr();
    step();
    stream_beats(258, 0);

    // 4b: pkt_len changed mid-packet
    pkt_len = 8'd4;
    do_clr();
    step();
    stream_beats(10, 1);

    // 5: clr mid-packet with 5 entries and overflow set
    pkt_len = 8'd3;
    sample_en = 1'b0;
    do_clr();
    m_axis_tready = 1'b0;
    sample_en = 1'b1;
    for (int i = 0; i < 17; i++) begin
      lfsr_data = 8'h60 + 8'(i);
      step();
    end
    sample_en = 1'b0;
    chk("t5_overflow_set", {31'd0, overflow}, 32'd1);
    m_axis_tready = 1'b1;
    for (int i = 0; i < 11; i++) step();
    chk("t5_level5", {27'd0, fifo_level}, 32'd5);
    chk("t5_tdata", {24'd0, m_axis_tdata}, 32'h6B);
    chk("t5_tlast_midpkt", {31'd0, m_axis_tlast}, 32'd1);
    do_clr();
    chk("t5_tvalid", {31'd0, m_axis_tvalid}, 32'd0);
    chk("t5_level", {27'd0, fifo_level}, 32'd0);
    chk("t5_overflow", {31'd0, overflow}, 32'd0);
    sample_en = 1'b1;
    lfsr_data = 8'h77;
    step();
    stream_beats(3, 2);

    // 6: async reset between edges while tvalid=1
    chk("t6_pre_tvalid", {31'd0, m_axis_tvalid}, 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("t6_tvalid", {31'd0, m_axis_tvalid}, 32'd0);
    chk("t6_tlast", {31'd0, m_axis_tlast}, 32'd0);
    chk("t6_tdata", {24'd0, m_axis_tdata}, 32'd0);
    chk("t6_level", {27'd0, fifo_level}, 32'd0);
    chk("t6_overflow", {31'd0, overflow}, 32'd0);
    sample_en = 1'b0;
    step();
    rst = 1'b0;
    step();
    chk("t6_post_tvalid", {31'd0, m_axis_tvalid}, 32'd0);
    chk("t6_post_level", {27'd0, fifo_level}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
